// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit/load inputs and pin-level outputs of the 7-segment scan driver.
// The master drives the digits, dp_mask and load; the slave (the driver) drives the pins.
interface seg7_scan_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dp_mask;
  logic       load;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  modport master (
    output digit0, digit1, digit2, digit3, dp_mask, load,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  digit0, digit1, digit2, digit3, dp_mask, load,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 4-digit 7-segment driver.
// Digits are captured into a shadow register on load and copied to the displayed
// register only at frame boundaries, so a frame never shows a mix of old and new digits.
// Each digit slot starts with BLANK_CYC cycles of all anodes off to suppress ghosting.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module seg7_scan_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic       clk,
  input logic       reset,
  seg7_scan_if.slave bus
);

  localparam int              PC_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(REFRESH_DIV - 1);
  localparam logic [PC_W-1:0] PC_BLANK = PC_W'(BLANK_CYC);
  localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic            DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [3:0]      AN_OFF   = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [PC_W-1:0] pc;
  logic [1:0]      slot;
  logic            pc_last;
  logic            boundary;

  logic [3:0][3:0] in_dig;
  logic [3:0][3:0] shadow_dig;
  logic [3:0][3:0] disp_dig;
  logic [3:0]      shadow_dp;
  logic [3:0]      disp_dp;
  logic            pending;

  logic [3:0]      lz_mask;
  logic [6:0]      seg_hi;
  logic [3:0]      an_hi;

  logic [6:0]      seg_q;
  logic            dp_q;
  logic [3:0]      an_q;
  logic            frame_done_q;

  assign in_dig   = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  assign pc_last  = (pc == PC_LAST);
  assign boundary = pc_last && (slot == 2'd3);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic z3, z2, z1;
  assign z3 = (disp_dig[3] == 4'h0);
  assign z2 = z3 && (disp_dig[2] == 4'h0);
  assign z1 = z2 && (disp_dig[1] == 4'h0);
  // Digit 0 is always shown, so its mask bit is tied low.
  assign lz_mask = {z3, z2, z1, 1'b0};
`else
  assign lz_mask = 4'h0;
`endif

  // Active-high segment pattern and anode select for the slot being scanned.
  always_comb begin
    seg_hi = lz_mask[slot] ? 7'h00 : decode(disp_dig[slot]);
    an_hi  = 4'b0001 << slot;
  end

  // Prescaler wraps every REFRESH_DIV cycles and advances the digit slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= '0;
      slot <= 2'd0;
    end else if (pc_last) begin
      pc   <= '0;
      slot <= slot + 2'd1;
    end else begin
      pc <= pc + PC_W'(1);
    end
  end

  // Shadow capture and frame-synchronous transfer; a load on the boundary bypasses the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_dig <= '0;
      shadow_dp  <= 4'h0;
      disp_dig   <= '0;
      disp_dp    <= 4'h0;
      pending    <= 1'b0;
    end else if (boundary && bus.load) begin
      shadow_dig <= in_dig;
      shadow_dp  <= bus.dp_mask;
      disp_dig   <= in_dig;
      disp_dp    <= bus.dp_mask;
      pending    <= 1'b0;
    end else if (boundary && pending) begin
      disp_dig <= shadow_dig;
      disp_dp  <= shadow_dp;
      pending  <= 1'b0;
    end else if (bus.load) begin
      shadow_dig <= in_dig;
      shadow_dp  <= bus.dp_mask;
      pending    <= 1'b1;
    end
  end

  // Registered pin drive: blanking gap at the start of each slot, then one anode on.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= boundary;
      if (pc < PC_BLANK) begin
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
        dp_q  <= DP_OFF;
      end else begin
        an_q  <= AN_ACTIVE_LOW ? ~an_hi : an_hi;
        seg_q <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_q  <= SEG_ACTIVE_LOW ? ~disp_dp[slot] : disp_dp[slot];
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: frame-by-frame check of the scan driver with REFRESH_DIV=8, BLANK_CYC=2.
// Expected frames are queued when a load is driven and taken at each frame boundary.
module tb_seg7_scan_driver;
  localparam int RD = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
  } exp_t;

  typedef struct {
    logic [15:0] digs;
    logic [3:0]  mask;
    exp_t        want;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t cur_exp;
  exp_t q[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  seg7_scan_if bus();

  seg7_scan_driver #(
    .REFRESH_DIV(RD),
    .BLANK_CYC(BC),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[d];
  endfunction

  function automatic exp_t make_exp(input logic [15:0] digs, input logic [3:0] mask);
    exp_t e;
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    for (int k = 3; k >= 0; k--) begin
      e.seg[k] = ~seg_code(digs[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      lead = lead && (digs[4*k +: 4] == 4'h0);
      if (lead && k != 0) e.seg[k] = 7'h7F;
`endif
      e.dp[k] = ~mask[k];
    end
    return e;
  endfunction

  function automatic vec_t make_vec(input logic [15:0] digs, input logic [3:0] mask);
    vec_t v;
    v.digs = digs;
    v.mask = mask;
    v.want = make_exp(digs, mask);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cycle=%0d {an,seg,dp,frame_done} got %h expected %h", name, cyc, act, want);
    end
  endtask

  task automatic drive_load(input vec_t v);
    bus.digit0  = v.digs[3:0];
    bus.digit1  = v.digs[7:4];
    bus.digit2  = v.digs[11:8];
    bus.digit3  = v.digs[15:12];
    bus.dp_mask = v.mask;
    bus.load    = 1'b1;
    q.push_back(v.want);
  endtask

  // One full frame starting right after a boundary edge (or reset release).
  // Load is driven before step index la / lb so it is sampled on that step's edge.
  task automatic run_frame(input int la, input vec_t va, input int lb, input vec_t vb);
    logic [3:0] an_x;
    logic [6:0] seg_x;
    logic       dp_x;
    logic       fd_x;
    for (int i = 0; i < 4*RD; i++) begin
      int s;
      int j;
      if (i == la) drive_load(va);
      else if (i == lb) drive_load(vb);
      step();
      bus.load = 1'b0;
      s = i / RD;
      j = i % RD;
      if (j < BC) begin
        an_x  = 4'hF;
        seg_x = 7'h7F;
        dp_x  = 1'b1;
      end else begin
        an_x  = ~(4'b0001 << s);
        seg_x = cur_exp.seg[s];
        dp_x  = cur_exp.dp[s];
      end
      fd_x = (i == 4*RD-1);
      check("scan", {bus.an, bus.seg, bus.dp, bus.frame_done}, {an_x, seg_x, dp_x, fd_x});
    end
    if (q.size() > 0) begin
      cur_exp = q[$];
      q.delete();
    end
  endtask

  initial begin
    vec_t none;
    vecs[0] = '{16'h1234, 4'b0001, '{{7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110}};
    vecs[1] = '{16'hFEDC, 4'b1010, '{{7'h0E, 7'h06, 7'h21, 7'h46}, 4'b0101}};
    vecs[2] = '{16'h89AB, 4'b1111, '{{7'h00, 7'h10, 7'h08, 7'h03}, 4'b0000}};
    vecs[3] = '{16'h7650, 4'b0100, '{{7'h78, 7'h02, 7'h12, 7'h40}, 4'b1011}};
    none = vecs[0];

    reset       = 1'b1;
    bus.digit0  = 4'h0;
    bus.digit1  = 4'h0;
    bus.digit2  = 4'h0;
    bus.digit3  = 4'h0;
    bus.dp_mask = 4'h0;
    bus.load    = 1'b0;

    // Reset held for 3 cycles: all outputs inactive.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset", {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    reset   = 1'b0;
    cur_exp = make_exp(16'h0000, 4'h0);

    // First frame after release: frame_done on the 32nd cycle, all-zero display.
    run_frame(-1, none, -1, none);

    // Table vectors loaded mid-frame; each shows only from the following frame.
    for (int v = 0; v < 4; v++) run_frame(5 + 3*v, vecs[v], -1, none);
    run_frame(-1, none, -1, none);

    // Two loads in one frame: only the last one is ever displayed.
    run_frame(4, make_vec(16'h0007, 4'h0), 20, make_vec(16'h0009, 4'h0));
    run_frame(-1, none, -1, none);

    // Load on the boundary cycle goes straight to the display.
    run_frame(31, make_vec(16'h000A, 4'h0), -1, none);
    run_frame(-1, none, -1, none);
    run_frame(-1, none, -1, none);

    // Leading zeros (blanked only when the option is built in).
    run_frame(10, make_vec(16'h0050, 4'h0), -1, none);
    run_frame(-1, none, -1, none);

    // Reset mid-scan with a pending load: shadow is lost, display returns to zero.
    drive_load(vecs[1]);
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("midreset", {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    reset = 1'b0;
    q.delete();
    cur_exp = make_exp(16'h0000, 4'h0);
    run_frame(-1, none, -1, none);
    run_frame(-1, none, -1, none);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
